// File: rtl/per2axi_res_channel.sv
// Response stage of the per2axi bridge: merges AXI R and B beats into single-cycle
// peripheral responses, picking the 32-bit half of each read beat from a per-ID lane table.
module per2axi_res_channel #(
    parameter int PER_ADDR_WIDTH = 32,
    parameter int PER_ID_WIDTH   = 5,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 6,
    parameter int AXI_ID_WIDTH   = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [PER_ID_WIDTH-1:0]   per_slave_r_id_o,
    output logic [31:0]               per_slave_r_rdata_o,
    input  logic                      axi_master_r_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0] axi_master_r_data_i,
    input  logic [1:0]                axi_master_r_resp_i,
    input  logic                      axi_master_r_last_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_r_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_r_user_i,
    output logic                      axi_master_r_ready_o,
    input  logic                      axi_master_b_valid_i,
    input  logic [1:0]                axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_master_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0] axi_master_b_user_i,
    output logic                      axi_master_b_ready_o,
    input  logic                      trans_req_i,
    input  logic [AXI_ID_WIDTH-1:0]   trans_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0] trans_add_i
);

    // Out-of-range IDs decode to all zeros, which doubles as the range check.
    function automatic logic [PER_ID_WIDTH-1:0] id_onehot(input logic [AXI_ID_WIDTH-1:0] id);
        logic [PER_ID_WIDTH-1:0] oh;
        oh = {PER_ID_WIDTH{1'b0}};
        for (int i = 0; i < PER_ID_WIDTH; i++) begin
            oh[i] = (id == AXI_ID_WIDTH'(i));
        end
        return oh;
    endfunction

    logic [PER_ID_WIDTH-1:0] lane_q, lane_d;
    logic                    prio_q, prio_d;
    logic                    valid_q, valid_d;
    logic                    opc_q, opc_d;
    logic [PER_ID_WIDTH-1:0] id_q, id_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    grant_r_s, grant_b_s;
    logic [PER_ID_WIDTH-1:0] r_oh_s, b_oh_s;
    logic                    unused_inputs_s;

    assign unused_inputs_s = ^{axi_master_r_last_i, axi_master_r_user_i, axi_master_b_user_i,
                               trans_add_i, axi_master_r_data_i};

    // Arbitration, lane table update and next response computation.
    always_comb begin
        r_oh_s    = id_onehot(axi_master_r_id_i);
        b_oh_s    = id_onehot(axi_master_b_id_i);
        grant_r_s = axi_master_r_valid_i & (~axi_master_b_valid_i | ~prio_q);
        grant_b_s = axi_master_b_valid_i & ~grant_r_s;
        lane_d    = lane_q;
        prio_d    = prio_q;
        valid_d   = 1'b0;
        opc_d     = opc_q;
        id_d      = id_q;
        rdata_d   = rdata_q;

        if (trans_req_i) begin
            for (int i = 0; i < PER_ID_WIDTH; i++) begin
                if (trans_id_i == AXI_ID_WIDTH'(i)) begin
                    lane_d[i] = trans_add_i[2];
                end else begin
                    lane_d[i] = lane_q[i];
                end
            end
        end else begin
            lane_d = lane_q;
        end

        if (axi_master_r_valid_i && axi_master_b_valid_i) begin
            prio_d = ~prio_q;
        end else begin
            prio_d = prio_q;
        end

        // Lane lookup uses lane_q, so a same-cycle table write is not yet visible.
        if (grant_r_s) begin
            valid_d = 1'b1;
            opc_d   = axi_master_r_resp_i[1] | ~(|r_oh_s);
            id_d    = r_oh_s;
            rdata_d = (|(lane_q & r_oh_s)) ? axi_master_r_data_i[63:32]
                                           : axi_master_r_data_i[31:0];
        end else if (grant_b_s) begin
            valid_d = 1'b1;
            opc_d   = axi_master_b_resp_i[1] | ~(|b_oh_s);
            id_d    = b_oh_s;
            rdata_d = 32'h0000_0000;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lane_q  <= {PER_ID_WIDTH{1'b0}};
            prio_q  <= 1'b0;
            valid_q <= 1'b0;
            opc_q   <= 1'b0;
            id_q    <= {PER_ID_WIDTH{1'b0}};
            rdata_q <= 32'h0000_0000;
        end else begin
            lane_q  <= lane_d;
            prio_q  <= prio_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
        end
    end

    assign axi_master_r_ready_o = grant_r_s;
    assign axi_master_b_ready_o = grant_b_s;
    assign per_slave_r_valid_o  = valid_q;
    assign per_slave_r_opc_o    = opc_q;
    assign per_slave_r_id_o     = id_q;
    assign per_slave_r_rdata_o  = rdata_q;

endmodule

// File: tb/tb_per2axi_res_channel.sv
// Table-driven bench for per2axi_res_channel: each vector is one clock cycle; the
// expected response is queued when driven and compared after the following edge.
module tb_per2axi_res_channel;

    logic        clk;
    logic        rst_ni;
    logic        per_slave_r_valid_o;
    logic        per_slave_r_opc_o;
    logic [4:0]  per_slave_r_id_o;
    logic [31:0] per_slave_r_rdata_o;
    logic        r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [2:0]  r_id;
    logic [5:0]  r_user;
    logic        r_ready;
    logic        b_valid;
    logic [1:0]  b_resp;
    logic [2:0]  b_id;
    logic [5:0]  b_user;
    logic        b_ready;
    logic        trans_req;
    logic [2:0]  trans_id;
    logic [31:0] trans_add;

    per2axi_res_channel dut (
        .clk_i                (clk),
        .rst_ni               (rst_ni),
        .per_slave_r_valid_o  (per_slave_r_valid_o),
        .per_slave_r_opc_o    (per_slave_r_opc_o),
        .per_slave_r_id_o     (per_slave_r_id_o),
        .per_slave_r_rdata_o  (per_slave_r_rdata_o),
        .axi_master_r_valid_i (r_valid),
        .axi_master_r_data_i  (r_data),
        .axi_master_r_resp_i  (r_resp),
        .axi_master_r_last_i  (r_last),
        .axi_master_r_id_i    (r_id),
        .axi_master_r_user_i  (r_user),
        .axi_master_r_ready_o (r_ready),
        .axi_master_b_valid_i (b_valid),
        .axi_master_b_resp_i  (b_resp),
        .axi_master_b_id_i    (b_id),
        .axi_master_b_user_i  (b_user),
        .axi_master_b_ready_o (b_ready),
        .trans_req_i          (trans_req),
        .trans_id_i           (trans_id),
        .trans_add_i          (trans_add)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        treq;
        logic [2:0]  tid;
        logic [31:0] tadd;
        logic        rv;
        logic [63:0] rdata;
        logic [1:0]  rresp;
        logic [2:0]  rid;
        logic        bv;
        logic [1:0]  bresp;
        logic [2:0]  bid;
        logic        exp_rr;
        logic        exp_br;
        logic        exp_v;
        logic        chk;
        logic [4:0]  exp_id;
        logic        exp_opc;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          idx;
        logic        v;
        logic        chk;
        logic [4:0]  id;
        logic        opc;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[20];
    int   nchecks;
    int   nerrors;

    function automatic vec_t mk(input logic rst_n, input logic treq, input logic [2:0] tid,
                                input logic [31:0] tadd, input logic rv, input logic [63:0] rd,
                                input logic [1:0] rresp, input logic [2:0] rid, input logic bv,
                                input logic [1:0] bresp, input logic [2:0] bid,
                                input logic exp_rr, input logic exp_br, input logic exp_v,
                                input logic chk, input logic [4:0] exp_id, input logic exp_opc,
                                input logic [31:0] exp_rdata);
        vec_t t;
        t.rst_n = rst_n; t.treq = treq; t.tid = tid; t.tadd = tadd;
        t.rv = rv; t.rdata = rd; t.rresp = rresp; t.rid = rid;
        t.bv = bv; t.bresp = bresp; t.bid = bid;
        t.exp_rr = exp_rr; t.exp_br = exp_br; t.exp_v = exp_v; t.chk = chk;
        t.exp_id = exp_id; t.exp_opc = exp_opc; t.exp_rdata = exp_rdata;
        return t;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        @(negedge clk);
        rst_ni    = t.rst_n;
        trans_req = t.treq;
        trans_id  = t.tid;
        trans_add = t.tadd;
        r_valid   = t.rv;
        r_data    = t.rdata;
        r_resp    = t.rresp;
        r_id      = t.rid;
        r_last    = 1'($urandom_range(1, 0));
        r_user    = 6'($urandom);
        b_valid   = t.bv;
        b_resp    = t.bresp;
        b_id      = t.bid;
        b_user    = 6'($urandom);
        #1;
        check("r_ready", idx, {31'd0, r_ready}, {31'd0, t.exp_rr});
        check("b_ready", idx, {31'd0, b_ready}, {31'd0, t.exp_br});
        e.idx = idx; e.v = t.exp_v; e.chk = t.chk;
        e.id = t.exp_id; e.opc = t.exp_opc; e.rdata = t.exp_rdata;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            nchecks++;
            nerrors++;
            $display("FAIL scoreboard vec %0d: got empty queue expected entry", idx);
        end else begin
            e = sb_q.pop_front();
            check("valid_o", e.idx, {31'd0, per_slave_r_valid_o}, {31'd0, e.v});
            if (e.chk) begin
                check("id_o", e.idx, {27'd0, per_slave_r_id_o}, {27'd0, e.id});
                check("opc_o", e.idx, {31'd0, per_slave_r_opc_o}, {31'd0, e.opc});
                check("rdata_o", e.idx, per_slave_r_rdata_o, e.rdata);
            end
        end
    endtask

    localparam logic [63:0] D1 = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D3 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] D4 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DZ = 64'h0;

    initial begin
        nchecks = 0;
        nerrors = 0;
        rst_ni = 1'b0; trans_req = 1'b0; trans_id = 3'd0; trans_add = 32'd0;
        r_valid = 1'b0; r_data = 64'd0; r_resp = 2'd0; r_last = 1'b0; r_id = 3'd0;
        r_user = 6'd0; b_valid = 1'b0; b_resp = 2'd0; b_id = 3'd0; b_user = 6'd0;

        // rst treq tid tadd  rv data rresp rid  bv bresp bid  rr br v chk id opc rdata
        vecs[0]  = mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, DZ, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0,
                      1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 32'h0);
        vecs[1]  = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, DZ, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0,
                      1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 32'h0);
        vecs[2]  = mk(1'b1, 1'b1, 3'd2, 32'h1000_0004, 1'b0, DZ, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0,
                      1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 32'h0);
        vecs[3]  = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, D1, 2'b00, 3'd2, 1'b0, 2'b00, 3'd0,
                      1'b1, 1'b0, 1'b1, 1'b1, 5'b00100, 1'b0, 32'hAAAA_BBBB);
        vecs[4]  = mk(1'b1, 1'b1, 3'd1, 32'h1000_0000, 1'b0, DZ, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0,
                      1'b0, 1'b0, 1'b0, 1'b1, 5'b00100, 1'b0, 32'hAAAA_BBBB);
        vecs[5]  = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, D2, 2'b10, 3'd1, 1'b0, 2'b00, 3'd0,
                      1'b1, 1'b0, 1'b1, 1'b1, 5'b00010, 1'b1, 32'h3333_4444);
        // R id0 and B id3 together: R, B, R
        vecs[6]  = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, D3, 2'b00, 3'd0, 1'b1, 2'b00, 3'd3,
                      1'b1, 1'b0, 1'b1, 1'b1, 5'b00001, 1'b0, 32'h7777_8888);
        vecs[7]  = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, D3, 2'b00, 3'd0, 1'b1, 2'b00, 3'd3,
                      1'b0, 1'b1, 1'b1, 1'b1, 5'b01000, 1'b0, 32'h0);
        vecs[8]  = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, D3, 2'b00, 3'd0, 1'b1, 2'b00, 3'd3,
                      1'b1, 1'b0, 1'b1, 1'b1, 5'b00001, 1'b0, 32'h7777_8888);
        vecs[9]  = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, DZ, 2'b00, 3'd0, 1'b1, 2'b00, 3'd4,
                      1'b0, 1'b1, 1'b1, 1'b1, 5'b10000, 1'b0, 32'h0);
        // same-cycle table write is not seen by the concurrent R beat
        vecs[10] = mk(1'b1, 1'b1, 3'd0, 32'h0000_0004, 1'b1, D4, 2'b01, 3'd0, 1'b0, 2'b00, 3'd0,
                      1'b1, 1'b0, 1'b1, 1'b1, 5'b00001, 1'b0, 32'h89AB_CDEF);
        vecs[11] = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, D4, 2'b11, 3'd0, 1'b0, 2'b00, 3'd0,
                      1'b1, 1'b0, 1'b1, 1'b1, 5'b00001, 1'b1, 32'h0123_4567);
        vecs[12] = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, D4, 2'b00, 3'd5, 1'b0, 2'b00, 3'd0,
                      1'b1, 1'b0, 1'b1, 1'b1, 5'b00000, 1'b1, 32'h89AB_CDEF);
        vecs[13] = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, DZ, 2'b00, 3'd0, 1'b1, 2'b01, 3'd7,
                      1'b0, 1'b1, 1'b1, 1'b1, 5'b00000, 1'b1, 32'h0);
        vecs[14] = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, DZ, 2'b00, 3'd0, 1'b1, 2'b11, 3'd2,
                      1'b0, 1'b1, 1'b1, 1'b1, 5'b00100, 1'b1, 32'h0);
        vecs[15] = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, D1, 2'b00, 3'd2, 1'b0, 2'b00, 3'd0,
                      1'b1, 1'b0, 1'b1, 1'b1, 5'b00100, 1'b0, 32'hAAAA_BBBB);
        // reset with a response pending and a beat offered: beat is dropped
        vecs[16] = mk(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, D1, 2'b10, 3'd2, 1'b0, 2'b00, 3'd0,
                      1'b1, 1'b0, 1'b0, 1'b1, 5'b00000, 1'b0, 32'h0);
        vecs[17] = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, D1, 2'b00, 3'd2, 1'b0, 2'b00, 3'd0,
                      1'b1, 1'b0, 1'b1, 1'b1, 5'b00100, 1'b0, 32'hCCCC_DDDD);
        // priority returns to R after reset
        vecs[18] = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b1, D2, 2'b00, 3'd1, 1'b1, 2'b00, 3'd4,
                      1'b1, 1'b0, 1'b1, 1'b1, 5'b00010, 1'b0, 32'h3333_4444);
        vecs[19] = mk(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, DZ, 2'b00, 3'd0, 1'b0, 2'b00, 3'd0,
                      1'b0, 1'b0, 1'b0, 1'b1, 5'b00010, 1'b0, 32'h3333_4444);

        for (int i = 0; i < 20; i++) begin
            apply(vecs[i], i);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
